// File: rtl/dp_onchip_ram_ctrl.sv
// dp_onchip_ram_ctrl: true dual-port on-chip RAM behind two Avalon-MM slaves,
// with byte lanes, s1-priority collisions and a post-reset zero-fill engine.

module dp_onchip_ram_rdpipe #(
  parameter int DATA_W       = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              accept,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  if (READ_LATENCY == 2) begin : g_l2
    logic [DATA_W-1:0] stg_data;
    logic              stg_valid;

    // Stage 2 advances only on clken cycles; pulse is one cycle wide.
    always_ff @(posedge clk) begin
      if (reset) begin
        stg_data      <= '0;
        stg_valid     <= 1'b0;
        readdata      <= '0;
        readdatavalid <= 1'b0;
      end else begin
        readdatavalid <= 1'b0;
        if (clken) begin
          stg_valid <= accept;
          if (accept) begin
            stg_data <= word;
          end
          if (stg_valid) begin
            readdata      <= stg_data;
            readdatavalid <= 1'b1;
          end
        end
      end
    end
  end else begin : g_l1
    always_ff @(posedge clk) begin
      if (reset) begin
        readdata      <= '0;
        readdatavalid <= 1'b0;
      end else begin
        readdatavalid <= accept & clken;
        if (accept & clken) begin
          readdata <= word;
        end
      end
    end
  end

endmodule

module dp_onchip_ram_ctrl #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 16384,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_clken,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_clken,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                init_busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          clr_we;
  logic          ready;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          s1_hit, s2_hit;
  logic [IW-1:0] s1_idx, s2_idx;
  logic          s1_wr, s2_wr;
  logic          s1_rd, s2_rd;
  logic [DATA_W-1:0] s1_word, s2_word;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        // A held reset must not touch the array.
        clr_we = !reset_reset;
        cnt_d  = cnt_q + IW'(1);
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
      end
      default: begin
      end
    endcase
  end

  assign ready          = (state_q == READY);
  assign init_busy      = !ready;
  assign s1_waitrequest = !ready;
  assign s2_waitrequest = !ready;

  assign s1_hit = {1'b0, s1_address} < LIMIT;
  assign s2_hit = {1'b0, s2_address} < LIMIT;
  assign s1_idx = s1_address[IW-1:0];
  assign s2_idx = s2_address[IW-1:0];

  assign s1_wr = ready & s1_chipselect & s1_write & s1_clken & s1_hit;
  assign s2_wr = ready & s2_chipselect & s2_write & s2_clken & s2_hit;
  assign s1_rd = ready & s1_chipselect & s1_read & !s1_write & s1_clken;
  assign s2_rd = ready & s2_chipselect & s2_read & !s2_write & s2_clken;

  // Reads see the array before this edge's writes: old data on collision.
  assign s1_word = s1_hit ? mem[s1_idx] : '0;
  assign s2_word = s2_hit ? mem[s2_idx] : '0;

  // s1 lanes are applied last so they win on a same-address collision.
  always_ff @(posedge clk_clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end
    for (int i = 0; i < BE_W; i++) begin
      if (s2_wr && s2_byteenable[i]) begin
        mem[s2_idx][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      end
      if (s1_wr && s1_byteenable[i]) begin
        mem[s1_idx][i*8 +: 8] <= s1_writedata[i*8 +: 8];
      end
    end
  end

  dp_onchip_ram_rdpipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd1 (
    .clk           (clk_clk),
    .reset         (reset_reset),
    .clken         (s1_clken),
    .accept        (s1_rd),
    .word          (s1_word),
    .readdata      (s1_readdata),
    .readdatavalid (s1_readdatavalid)
  );

  dp_onchip_ram_rdpipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd2 (
    .clk           (clk_clk),
    .reset         (reset_reset),
    .clken         (s2_clken),
    .accept        (s2_rd),
    .word          (s2_word),
    .readdata      (s2_readdata),
    .readdatavalid (s2_readdatavalid)
  );

endmodule

// File: tb/tb_dp_onchip_ram_ctrl.sv
// tb_dp_onchip_ram_ctrl: drives one latency-1 and one latency-2 instance with
// identical directed traffic and checks both against a latency-counting model.

module tb_dp_onchip_ram_ctrl;

  localparam int DW  = 64;
  localparam int AW  = 8;
  localparam int DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] addr [2];
  logic          clken [2];
  logic          cs [2];
  logic          rd [2];
  logic          wr [2];
  logic [DW-1:0] wd [2];
  logic [7:0]    be [2];

  logic [DW-1:0] rdata [2][2];
  logic          rdv [2][2];
  logic          wreq [2][2];
  logic          busy [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dp_onchip_ram_ctrl #(
      .DATA_W         (DW),
      .ADDR_W         (AW),
      .DEPTH          (DEP),
      .READ_LATENCY   (k + 1),
      .CLEAR_ON_RESET (1)
    ) dut (
      .clk_clk          (clk),
      .reset_reset      (rst),
      .s1_address       (addr[0]),
      .s1_clken         (clken[0]),
      .s1_chipselect    (cs[0]),
      .s1_read          (rd[0]),
      .s1_write         (wr[0]),
      .s1_writedata     (wd[0]),
      .s1_byteenable    (be[0]),
      .s1_readdata      (rdata[k][0]),
      .s1_readdatavalid (rdv[k][0]),
      .s1_waitrequest   (wreq[k][0]),
      .s2_address       (addr[1]),
      .s2_clken         (clken[1]),
      .s2_chipselect    (cs[1]),
      .s2_read          (rd[1]),
      .s2_write         (wr[1]),
      .s2_writedata     (wd[1]),
      .s2_byteenable    (be[1]),
      .s2_readdata      (rdata[k][1]),
      .s2_readdatavalid (rdv[k][1]),
      .s2_waitrequest   (wreq[k][1]),
      .init_busy        (busy[k])
    );
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int k, int p, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d port=%0d actual=%h required=%h t=%0t",
               nm, k, p, act, exp, $time);
    end
  endtask

  // Model: word array, busy countdown, and per read a count of clken edges.
  logic [DW-1:0] mm [DEP];
  int            bcnt;
  logic          pv [2][2];
  int            pe [2][2];
  logic [DW-1:0] pd [2][2];
  logic          ev [2][2];
  logic [DW-1:0] ed [2][2];

  always @(posedge clk) begin : model
    logic          racc [2];
    logic          wacc [2];
    logic [DW-1:0] rw [2];
    if (rst) begin
      bcnt = DEP;
      for (int i = 0; i < DEP; i++) mm[i] = '0;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          pv[k][p] = 1'b0; pe[k][p] = 0; pd[k][p] = '0;
          ev[k][p] = 1'b0; ed[k][p] = '0;
        end
    end else begin
      for (int p = 0; p < 2; p++) begin
        racc[p] = (bcnt == 0) && cs[p] && rd[p] && !wr[p] && clken[p];
        wacc[p] = (bcnt == 0) && cs[p] && wr[p] && clken[p] && (int'(addr[p]) < DEP);
        rw[p]   = (int'(addr[p]) < DEP) ? mm[addr[p][3:0]] : '0;
      end
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          ev[k][p] = 1'b0;
          if (pv[k][p] && clken[p]) pe[k][p]++;
          if (pv[k][p] && pe[k][p] >= k + 1) begin
            ev[k][p] = 1'b1; ed[k][p] = pd[k][p]; pv[k][p] = 1'b0;
          end
          if (racc[p]) begin
            if (k == 0) begin
              ev[k][p] = 1'b1; ed[k][p] = rw[p];
            end else begin
              pv[k][p] = 1'b1; pd[k][p] = rw[p]; pe[k][p] = 1;
            end
          end
        end
      for (int i = 0; i < 8; i++) begin
        if (wacc[1] && be[1][i]) mm[addr[1][3:0]][i*8 +: 8] = wd[1][i*8 +: 8];
        if (wacc[0] && be[0][i]) mm[addr[0][3:0]][i*8 +: 8] = wd[0][i*8 +: 8];
      end
      if (bcnt > 0) bcnt--;
    end
  end

  int pc [2][2];
  initial for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) pc[k][p] = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) pc[k][p] += int'(rdv[k][p]);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 0, DW'(busy[k]), DW'(bcnt > 0));
        for (int p = 0; p < 2; p++) begin
          chk("waitrequest", k, p, DW'(wreq[k][p]), DW'(bcnt > 0));
          chk("readdatavalid", k, p, DW'(rdv[k][p]), DW'(ev[k][p]));
          chk("readdata", k, p, rdata[k][p], ed[k][p]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; clken[p] = 1'b1; cs[p] = 1'b0; rd[p] = 1'b0;
      wr[p] = 1'b0; wd[p] = '0; be[p] = '0;
    end
  endtask

  task automatic do_write(int p, logic [AW-1:0] a, logic [DW-1:0] d, logic [7:0] b);
    cs[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; wd[p] = d; be[p] = b;
    cyc();
    cs[p] = 1'b0; wr[p] = 1'b0;
  endtask

  task automatic do_read(int p, logic [AW-1:0] a);
    cs[p] = 1'b1; rd[p] = 1'b1; addr[p] = a;
    cyc();
    cs[p] = 1'b0; rd[p] = 1'b0;
  endtask

  task automatic expect_rd(int p, logic [DW-1:0] exp, string nm);
    bit seen [2];
    seen[0] = 1'b0; seen[1] = 1'b0;
    for (int n = 0; n < 8 && !(seen[0] && seen[1]); n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (!seen[k] && rdv[k][p]) begin
          seen[k] = 1'b1;
          chk(nm, k, p, rdata[k][p], exp);
        end
    end
    for (int k = 0; k < 2; k++)
      if (!seen[k]) begin
        total++; bad++;
        $display("FAIL %s inst=%0d port=%0d actual=no_pulse required=pulse", nm, k, p);
      end
  endtask

  task automatic busy_len(string nm);
    int n [2];
    n[0] = 0; n[1] = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1]) break;
      for (int k = 0; k < 2; k++) n[k] += int'(busy[k]);
    end
    for (int k = 0; k < 2; k++) chk(nm, k, 0, DW'(n[k]), DW'(16));
  endtask

  initial begin
    int snap [2];
    idle();
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    busy_len("first_clear_len");

    // Pre-fill, then reset and check the zero fill.
    for (int a = 0; a < DEP; a++)
      do_write(a % 2, AW'(a), 64'hC0DE_0000_0000_0000 | DW'(a), 8'hFF);
    do_read(1, 8'd5);
    expect_rd(1, 64'hC0DE_0000_0000_0005, "prefill_rd5");
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    busy_len("clear_len");
    do_read(0, 8'd5);
    expect_rd(0, 64'h0, "cleared_rd5");

    // Byte-lane write.
    do_write(0, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_write(0, 8'd3, 64'h1122_3344_5566_7788, 8'h0F);
    do_read(1, 8'd3);
    expect_rd(1, 64'hFFFF_FFFF_5566_7788, "byte_lanes");

    // Same-address write collisions.
    cs[0] = 1; wr[0] = 1; addr[0] = 7; wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; be[0] = 8'h0F;
    cs[1] = 1; wr[1] = 1; addr[1] = 7; wd[1] = 64'h5555_5555_5555_5555; be[1] = 8'hFF;
    cyc(); idle();
    do_read(0, 8'd7);
    expect_rd(0, 64'h5555_5555_AAAA_AAAA, "ww_collide_0f");
    cs[0] = 1; wr[0] = 1; addr[0] = 7; wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; be[0] = 8'hFF;
    cs[1] = 1; wr[1] = 1; addr[1] = 7; wd[1] = 64'h5555_5555_5555_5555; be[1] = 8'hFF;
    cyc(); idle();
    do_read(1, 8'd7);
    expect_rd(1, 64'hAAAA_AAAA_AAAA_AAAA, "ww_collide_ff");

    // Read/write collision returns old data.
    do_write(1, 8'd9, 64'd1, 8'hFF);
    cs[0] = 1; wr[0] = 1; addr[0] = 9; wd[0] = 64'd2; be[0] = 8'hFF;
    cs[1] = 1; rd[1] = 1; addr[1] = 9;
    cyc(); idle();
    expect_rd(1, 64'd1, "rw_old_data");
    do_read(1, 8'd9);
    expect_rd(1, 64'd2, "rw_new_data");

    // clken stall on s1 after an accepted read.
    snap[0] = pc[0][0]; snap[1] = pc[1][0];
    do_read(0, 8'd7);
    clken[0] = 1'b0;
    cyc(); cyc(); cyc();
    clken[0] = 1'b1;
    cyc();
    @(negedge clk);
    chk("stall_pulse_t5", 1, 0, DW'(rdv[1][0]), DW'(1));
    chk("stall_data_t5", 1, 0, rdata[1][0], 64'hAAAA_AAAA_AAAA_AAAA);
    cyc(); cyc();
    for (int k = 0; k < 2; k++) chk("stall_pulse_count", k, 0, DW'(pc[k][0] - snap[k]), DW'(1));

    // read+write together is a write only; out-of-range write dropped.
    snap[0] = pc[0][0]; snap[1] = pc[1][0];
    cs[0] = 1; rd[0] = 1; wr[0] = 1; addr[0] = 10; wd[0] = 64'h0BAD_F00D; be[0] = 8'hFF;
    cyc(); idle();
    cyc(); cyc(); cyc();
    for (int k = 0; k < 2; k++) chk("rw_same_port_nopulse", k, 0, DW'(pc[k][0] - snap[k]), DW'(0));
    do_write(1, 8'd20, 64'h1234, 8'hFF);
    // Back-to-back reads at full rate on s2.
    cs[1] = 1; rd[1] = 1;
    addr[1] = 10; cyc();
    addr[1] = 4;  cyc();
    addr[1] = 3;  cyc();
    idle();
    cyc(); cyc();
    do_read(1, 8'd4);
    expect_rd(1, 64'hC0DE_0000_0000_0004 & 64'h0, "oor_write_dropped");

    // Reset mid-clear restarts the fill.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    busy_len("restart_clear_len");
    do_read(0, 8'd200);
    expect_rd(0, 64'h0, "oor_read_zero");
    do_read(1, 8'd10);
    expect_rd(1, 64'h0, "cleared_rd10");
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
